// File: rtl/load_rs_param_pkg.sv
// Shared definitions for the load reservation station: default widths,
// load subtype encodings and the per-entry control record.
package load_rs_param_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int TAG_W_DEF = 6;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  // Width-independent part of an entry; tag/base/offset/rob are sized by the top.
  typedef struct packed {
    logic       valid;
    logic       base_rdy;
    logic [2:0] sub;
  } rs_entry_ctrl_t;

endpackage

// File: rtl/load_rs_param_age.sv
// Age matrix for the load reservation station: tracks relative entry age
// and picks the single oldest entry among a request mask.
module rs_age_matrix
  import load_rs_param_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic [DEPTH-1:0] alloc,
  input  logic [DEPTH-1:0] free,
  input  logic [DEPTH-1:0] req,
  output logic [DEPTH-1:0] grant
);

  // older_r[i][j] = 1 means entry i is older than entry j
  logic [DEPTH-1:0][DEPTH-1:0] older_r;
  logic [DEPTH-1:0][DEPTH-1:0] older_nxt_s;
  logic [DEPTH-1:0]            senior_s [DEPTH];

  // Next matrix: a new entry is younger than all others; a freed row loses seniority.
  always_comb begin
    older_nxt_s = older_r;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        older_nxt_s[i][j] = (i == j)              ? 1'b0 :
                            alloc[j]              ? 1'b1 :
                            (alloc[i] || free[i]) ? 1'b0 : older_r[i][j];
      end
    end
  end

  // Matrix register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      older_r <= '0;
    end else if (flush) begin
      older_r <= '0;
    end else begin
      older_r <= older_nxt_s;
    end
  end

  // Grant the requester that no other requester is older than.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      senior_s[i] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        senior_s[i][j] = req[j] & older_r[j][i];
      end
      grant[i] = req[i] & ~(|senior_s[i]);
    end
  end

endmodule

// File: rtl/load_rs_param.sv
// Load reservation station: holds dispatched loads, wakes them from the CDBs,
// and issues the oldest ready one as base+offset through a registered stage.
module load_rs_param
  import load_rs_param_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int DEPTH = 4,
  parameter int CDB_N = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          disp_valid,
  output logic                          disp_ready,
  input  logic [2:0]                    disp_sub,
  input  logic [TAG_W-1:0]              disp_rob,
  input  logic                          disp_base_rdy,
  input  logic [XLEN-1:0]               disp_base,
  input  logic [TAG_W-1:0]              disp_base_tag,
  input  logic [XLEN-1:0]               disp_offset,
  input  logic [CDB_N-1:0]              cdb_valid,
  input  logic [CDB_N*TAG_W-1:0]        cdb_tag,
  input  logic [CDB_N*XLEN-1:0]         cdb_data,
  output logic                          issue_valid,
  input  logic                          issue_ready,
  output logic [XLEN-1:0]               issue_addr,
  output logic [2:0]                    issue_sub,
  output logic [TAG_W-1:0]              issue_rob,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [DEPTH-1:0] ONE_V = {{(DEPTH-1){1'b0}}, 1'b1};

  rs_entry_ctrl_t   ctrl_r [DEPTH];
  logic [TAG_W-1:0] rob_r  [DEPTH];
  logic [TAG_W-1:0] tag_r  [DEPTH];
  logic [XLEN-1:0]  base_r [DEPTH];
  logic [XLEN-1:0]  off_r  [DEPTH];

  logic [TAG_W-1:0] cdb_tag_s   [CDB_N];
  logic [XLEN-1:0]  cdb_data_s  [CDB_N];
  logic [XLEN-1:0]  wake_data_s [DEPTH];
  logic [DEPTH-1:0] valid_s, req_s, grant_s, alloc_s, free_s, valid_nxt_s, wake_s;
  logic             cap_hit_s, disp_fire_s, xfer_s;
  logic [XLEN-1:0]  cap_data_s, sel_base_s, sel_off_s;
  logic [2:0]       sel_sub_s;
  logic [TAG_W-1:0] sel_rob_s;
  logic [OCC_W-1:0] occ_nxt_s, occupancy_r;
  logic             disp_ready_r, issue_valid_r;
  logic [XLEN-1:0]  issue_addr_r;
  logic [2:0]       issue_sub_r;
  logic [TAG_W-1:0] issue_rob_r;

  // Unpack CDB buses and form per-entry status vectors.
  always_comb begin
    for (int p = 0; p < CDB_N; p++) begin
      cdb_tag_s[p]  = cdb_tag[p*TAG_W +: TAG_W];
      cdb_data_s[p] = cdb_data[p*XLEN +: XLEN];
    end
    for (int i = 0; i < DEPTH; i++) begin
      valid_s[i] = ctrl_r[i].valid;
      req_s[i]   = ctrl_r[i].valid & ctrl_r[i].base_rdy;
    end
  end

  // Wakeup and dispatch-capture compares; scanning high-to-low lets the lowest port win.
  always_comb begin
    cap_hit_s  = 1'b0;
    cap_data_s = '0;
    for (int p = CDB_N - 1; p >= 0; p--) begin
      cap_data_s = (cdb_valid[p] && cdb_tag_s[p] == disp_base_tag) ? cdb_data_s[p] : cap_data_s;
      cap_hit_s  = cap_hit_s | (cdb_valid[p] && cdb_tag_s[p] == disp_base_tag);
    end
    for (int i = 0; i < DEPTH; i++) begin
      wake_s[i]      = 1'b0;
      wake_data_s[i] = '0;
      for (int p = CDB_N - 1; p >= 0; p--) begin
        wake_data_s[i] = (cdb_valid[p] && cdb_tag_s[p] == tag_r[i]) ? cdb_data_s[p] : wake_data_s[i];
        wake_s[i]      = wake_s[i] | (cdb_valid[p] && cdb_tag_s[p] == tag_r[i]);
      end
      wake_s[i] = wake_s[i] & ctrl_r[i].valid & ~ctrl_r[i].base_rdy;
    end
  end

  rs_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .alloc (alloc_s),
    .free  (free_s),
    .req   (req_s),
    .grant (grant_s)
  );

  // Allocation, transfer and next-valid computation; the lowest clear valid bit is ~v & (v+1).
  always_comb begin
    disp_fire_s = disp_valid & disp_ready_r;
    alloc_s     = disp_fire_s ? (~valid_s & (valid_s + ONE_V)) : '0;
    xfer_s      = (|grant_s) & (~issue_valid_r | issue_ready);
    free_s      = xfer_s ? grant_s : '0;
    valid_nxt_s = flush ? '0 : ((valid_s & ~free_s) | alloc_s);
    occ_nxt_s   = '0;
    sel_base_s  = '0;
    sel_off_s   = '0;
    sel_sub_s   = 3'b000;
    sel_rob_s   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_nxt_s  = occ_nxt_s + OCC_W'(valid_nxt_s[i]);
      sel_base_s = sel_base_s | ({XLEN{grant_s[i]}} & base_r[i]);
      sel_off_s  = sel_off_s  | ({XLEN{grant_s[i]}} & off_r[i]);
      sel_sub_s  = sel_sub_s  | ({3{grant_s[i]}} & ctrl_r[i].sub);
      sel_rob_s  = sel_rob_s  | ({TAG_W{grant_s[i]}} & rob_r[i]);
    end
  end

  // Entry storage: allocate (with same-cycle CDB capture) or wake a waiting base.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_r[i] <= '0;
        rob_r[i]  <= '0;
        tag_r[i]  <= '0;
        base_r[i] <= '0;
        off_r[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_r[i].valid <= valid_nxt_s[i];
        if (alloc_s[i]) begin
          ctrl_r[i].sub      <= disp_sub;
          ctrl_r[i].base_rdy <= disp_base_rdy | cap_hit_s;
          rob_r[i]           <= disp_rob;
          tag_r[i]           <= disp_base_tag;
          base_r[i]          <= disp_base_rdy ? disp_base : cap_data_s;
          off_r[i]           <= disp_offset;
        end else if (wake_s[i]) begin
          ctrl_r[i].base_rdy <= 1'b1;
          base_r[i]          <= wake_data_s[i];
        end
      end
    end
  end

  // Output stage: refill when empty or being consumed, hold otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      issue_valid_r <= 1'b0;
      issue_addr_r  <= '0;
      issue_sub_r   <= 3'b000;
      issue_rob_r   <= '0;
    end else if (flush) begin
      issue_valid_r <= 1'b0;
    end else if (xfer_s) begin
      issue_valid_r <= 1'b1;
      issue_addr_r  <= sel_base_s + sel_off_s;
      issue_sub_r   <= sel_sub_s;
      issue_rob_r   <= sel_rob_s;
    end else if (issue_ready) begin
      issue_valid_r <= 1'b0;
    end
  end

  // Status registers reflect entry state after each edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      occupancy_r  <= '0;
      disp_ready_r <= 1'b1;
    end else begin
      occupancy_r  <= occ_nxt_s;
      disp_ready_r <= ~(&valid_nxt_s);
    end
  end

  assign disp_ready  = disp_ready_r;
  assign occupancy   = occupancy_r;
  assign issue_valid = issue_valid_r;
  assign issue_addr  = issue_addr_r;
  assign issue_sub   = issue_sub_r;
  assign issue_rob   = issue_rob_r;

endmodule
